pc_unit: RTL and testbench

//  Parametrised program-counter unit for the unpipelined MIPS core: holds the fetch PC, selects

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/pc_next_mux.sv | 79 +++++++
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch path: PC state machine encoding, next-PC select codes
// and the state-transition helper used by pc_unit.
package mips_pkg;

    localparam int PC_W_DEF = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_HOLD = 3'd3,
        SEL_EXC  = 3'd4,
        SEL_ERET = 3'd5
    } pc_sel_t;

    // A trap (or return from it) keeps the core running even if halt is requested together.
    function automatic pc_state_t pc_next_state(
        input pc_state_t st,
        input logic      halt,
        input logic      exc,
        input logic      eret
    );
        pc_state_t ns;
        ns = st;
        case (st)
            BOOT: ns = RUN;
            RUN: begin
                if (exc || eret) begin
                    ns = RUN;
                end else if (halt) begin
                    ns = HALT;
                end else begin
                    ns = RUN;
                end
            end
            HALT: begin
                if (exc) begin
                    ns = RUN;
                end else begin
                    ns = HALT;
                end
            end
            default: ns = BOOT;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select for pc_unit: exc > eret > halt > stall > jump > branch > seq.
// Redirects are only honoured in RUN; HALT responds to the trap request alone.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int              PC_W    = PC_W_DEF,
    parameter int              STEP    = 1,
    parameter logic [PC_W-1:0] EXC_VEC = PC_W'(32'h0000_0080)
) (
    input  pc_state_t        i_state,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [PC_W-1:0]  i_epc,
    input  logic             i_exc,
    input  logic             i_eret,
    input  logic             i_halt,
    input  logic             i_stall,
    input  logic             i_jump,
    input  logic [PC_W-1:0]  i_jump_addr,
    input  logic             i_branch,
    input  logic [PC_W-1:0]  i_branch_off,
    output pc_sel_t          o_sel,
    output logic [PC_W-1:0]  o_next_pc,
    output logic [PC_W-1:0]  o_pc_plus
);

    localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

    logic [PC_W-1:0] w_pc_plus;
    pc_sel_t         w_sel;

    assign w_pc_plus = i_pc + STEP_V;
    assign o_pc_plus = w_pc_plus;
    assign o_sel     = w_sel;

    // Priority decode of the redirect sources for the current state.
    always_comb begin
        w_sel = SEL_HOLD;
        case (i_state)
            RUN: begin
                if (i_exc) begin
                    w_sel = SEL_EXC;
                end else if (i_eret) begin
                    w_sel = SEL_ERET;
                end else if (i_halt || i_stall) begin
                    w_sel = SEL_HOLD;
                end else if (i_jump) begin
                    w_sel = SEL_JMP;
                end else if (i_branch) begin
                    w_sel = SEL_BR;
                end else begin
                    w_sel = SEL_SEQ;
                end
            end
            HALT: begin
                if (i_exc) begin
                    w_sel = SEL_EXC;
                end else begin
                    w_sel = SEL_HOLD;
                end
            end
            default: w_sel = SEL_HOLD;
        endcase
    end

    // Branch offsets are relative to the delay-slot address, i.e. pc+STEP.
    always_comb begin
        o_next_pc = i_pc;
        case (w_sel)
            SEL_SEQ:  o_next_pc = w_pc_plus;
            SEL_BR:   o_next_pc = w_pc_plus + i_branch_off;
            SEL_JMP:  o_next_pc = i_jump_addr;
            SEL_HOLD: o_next_pc = i_pc;
            SEL_EXC:  o_next_pc = EXC_VEC;
            SEL_ERET: o_next_pc = i_epc;
            default:  o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit of the unpipelined MIPS core: BOOT/RUN/HALT state, fetch PC and trap EPC.
// Define PC_EXC_EN to add the trap/return ports (i_exc, i_eret, o_epc).
module pc_unit
    import mips_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              STEP      = 1,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0080)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_halt,
    input  logic             i_branch,
    input  logic [PC_W-1:0]  i_branch_off,
    input  logic             i_jump,
    input  logic [PC_W-1:0]  i_jump_addr,
`ifdef PC_EXC_EN
    input  logic             i_exc,
    input  logic             i_eret,
    output logic [PC_W-1:0]  o_epc,
`endif
    output logic [PC_W-1:0]  o_pc,
    output logic [PC_W-1:0]  o_pc_plus,
    output logic             o_valid,
    output logic             o_halted
);

    pc_state_t       r_state;
    pc_state_t       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_epc;
    pc_sel_t         w_sel;
    logic            w_exc;
    logic            w_eret;

`ifdef PC_EXC_EN
    logic [PC_W-1:0] r_epc;

    assign w_exc  = i_exc;
    assign w_eret = i_eret;
    assign w_epc  = r_epc;
    assign o_epc  = r_epc;

    // Trap return address is captured only when the trap is actually taken.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_epc <= {PC_W{1'b0}};
        end else if (w_sel == SEL_EXC) begin
            r_epc <= r_pc;
        end else begin
            r_epc <= r_epc;
        end
    end
`else
    assign w_exc  = 1'b0;
    assign w_eret = 1'b0;
    assign w_epc  = {PC_W{1'b0}};
`endif

    pc_next_mux #(
        .PC_W    (PC_W),
        .STEP    (STEP),
        .EXC_VEC (EXC_VEC)
    ) u_next_mux (
        .i_state      (r_state),
        .i_pc         (r_pc),
        .i_epc        (w_epc),
        .i_exc        (w_exc),
        .i_eret       (w_eret),
        .i_halt       (i_halt),
        .i_stall      (i_stall),
        .i_jump       (i_jump),
        .i_jump_addr  (i_jump_addr),
        .i_branch     (i_branch),
        .i_branch_off (i_branch_off),
        .o_sel        (w_sel),
        .o_next_pc    (w_pc_nxt),
        .o_pc_plus    (o_pc_plus)
    );

    // State transition decode.
    always_comb begin
        w_state_nxt = pc_next_state(r_state, i_halt, w_exc, w_eret);
    end

    // State and fetch PC registers; reset overrides every other input.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_VEC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign o_pc     = r_pc;
    assign o_valid  = (r_state == RUN) && !i_stall;
    assign o_halted = (r_state == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a reference model pushes expected PC/state per clock,
// popped and compared after each edge; a second 8-bit STEP=4 instance covers wrap-around.
module tb_pc_unit;

    typedef struct {
        logic [31:0] pc;
        int          st;
        logic [31:0] epc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall, halt, branch, jump, exc, eret;
    logic [31:0] off, jaddr;
    logic [31:0] o_pc, o_pc_plus, o_epc;
    logic        o_valid, o_halted;

    logic        j8, br8;
    logic [7:0]  ja8, off8;
    logic [7:0]  o_pc8, o_pc_plus8, o_epc8;
    logic        o_valid8, o_halted8;

    int          n_assert;
    int          n_fail;
    exp_t        sb_q[$];
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_epc;

    pc_unit #(.PC_W(32), .STEP(1)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_halt       (halt),
        .i_branch     (branch),
        .i_branch_off (off),
        .i_jump       (jump),
        .i_jump_addr  (jaddr),
`ifdef PC_EXC_EN
        .i_exc        (exc),
        .i_eret       (eret),
        .o_epc        (o_epc),
`endif
        .o_pc         (o_pc),
        .o_pc_plus    (o_pc_plus),
        .o_valid      (o_valid),
        .o_halted     (o_halted)
    );

    pc_unit #(.PC_W(8), .STEP(4)) dut8 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (1'b0),
        .i_halt       (1'b0),
        .i_branch     (br8),
        .i_branch_off (off8),
        .i_jump       (j8),
        .i_jump_addr  (ja8),
`ifdef PC_EXC_EN
        .i_exc        (1'b0),
        .i_eret       (1'b0),
        .o_epc        (o_epc8),
`endif
        .o_pc         (o_pc8),
        .o_pc_plus    (o_pc_plus8),
        .o_valid      (o_valid8),
        .o_halted     (o_halted8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model one clock of the reference, push its prediction, clock the DUT, compare.
    task automatic tick();
        exp_t        e;
        logic [31:0] npc;
        logic [31:0] nepc;
        int          nst;
        npc  = m_pc;
        nepc = m_epc;
        nst  = m_state;
        if (!rst_n) begin
            npc = 32'h0; nst = 0; nepc = 32'h0;
        end else if (m_state == 0) begin
            nst = 1;
        end else if (m_state == 2) begin
            if (exc) begin nepc = m_pc; npc = 32'h80; nst = 1; end
        end else begin
            if (exc) begin nepc = m_pc; npc = 32'h80; end
            else if (eret) npc = m_epc;
            else if (halt) nst = 2;
            else if (stall) npc = m_pc;
            else if (jump) npc = jaddr;
            else if (branch) npc = m_pc + 32'd1 + off;
            else npc = m_pc + 32'd1;
        end
        e.pc = npc; e.st = nst; e.epc = nepc;
        sb_q.push_back(e);
        m_pc = npc; m_state = nst; m_epc = nepc;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pc", o_pc, e.pc);
        check("halted", {31'h0, o_halted}, {31'h0, (e.st == 2)});
        check("valid", {31'h0, o_valid}, {31'h0, (e.st == 1) && !stall});
        check("pc_plus", o_pc_plus, e.pc + 32'd1);
`ifdef PC_EXC_EN
        check("epc", o_epc, e.epc);
`endif
    endtask

    initial begin
        logic [31:0] r;
        n_assert = 0; n_fail = 0;
        m_state = 0; m_pc = 32'h0; m_epc = 32'h0;
        rst_n = 1'b0; stall = 1'b0; halt = 1'b0; branch = 1'b0; jump = 1'b0;
        exc = 1'b0; eret = 1'b0; off = 32'h0; jaddr = 32'h0;
        j8 = 1'b0; br8 = 1'b0; ja8 = 8'h0; off8 = 8'h0;

        // Reset and boot
        tick(); tick();
        check("rst_pc", o_pc, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("boot_valid", {31'h0, o_valid}, 32'h0);
        tick(); check("run_pc0", o_pc, 32'h0); check("run_v0", {31'h0, o_valid}, 32'h1);
        tick(); check("run_pc1", o_pc, 32'h1);
        tick(); check("run_pc2", o_pc, 32'h2);
        tick(); check("run_pc3", o_pc, 32'h3);

        // Wrap and jump-over-branch on the 8-bit STEP=4 instance
        j8 = 1'b1; ja8 = 8'hFC;
        tick(); check("w8_load", {24'h0, o_pc8}, 32'hFC);
        j8 = 1'b0;
        tick(); check("w8_wrap", {24'h0, o_pc8}, 32'h00);
        j8 = 1'b1; ja8 = 8'h30; br8 = 1'b1; off8 = 8'h08;
        tick(); check("w8_jmp_wins", {24'h0, o_pc8}, 32'h30);
        j8 = 1'b0; br8 = 1'b0;
        tick(); check("w8_seq", {24'h0, o_pc8}, 32'h34);

        // Branches relative to pc+1
        jump = 1'b1; jaddr = 32'd10; tick();
        jump = 1'b0; branch = 1'b1; off = -32'sd3; tick();
        check("br_neg", o_pc, 32'd8);
        branch = 1'b0; jump = 1'b1; jaddr = 32'd10; tick();
        jump = 1'b0; branch = 1'b1; off = 32'd5; tick();
        check("br_pos", o_pc, 32'd16);
        branch = 1'b0;

        // Stall drops a redirect until it clears
        jump = 1'b1; jaddr = 32'd20; tick();
        stall = 1'b1; jaddr = 32'd100; tick();
        check("stall_hold", o_pc, 32'd20);
        check("stall_valid", {31'h0, o_valid}, 32'h0);
        stall = 1'b0; tick();
        check("stall_release", o_pc, 32'd100);
        jump = 1'b0;

        // Random redirect mix against the model
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            stall = r[0]; jump = r[1] & r[2]; branch = r[3];
            off = {{28{r[7]}}, r[7:4]};
            jaddr = $urandom;
            tick();
        end
        stall = 1'b0; jump = 1'b0; branch = 1'b0;

`ifdef PC_EXC_EN
        jump = 1'b1; jaddr = 32'd40; tick();
        jump = 1'b0; exc = 1'b1; tick();
        check("exc_pc", o_pc, 32'h80); check("exc_epc", o_epc, 32'd40);
        exc = 1'b0; eret = 1'b1; tick();
        check("eret_pc", o_pc, 32'd40);
        eret = 1'b0; halt = 1'b1; tick();
        halt = 1'b0; exc = 1'b1; tick();
        check("exc_halt_pc", o_pc, 32'h80);
        check("exc_halt_run", {31'h0, o_halted}, 32'h0);
        exc = 1'b0;
`endif

        // Halt freezes the PC until reset
        jump = 1'b1; jaddr = 32'd7; tick();
        jump = 1'b0; halt = 1'b1; tick();
        check("halt_pc", o_pc, 32'd7);
        check("halt_flag", {31'h0, o_halted}, 32'h1);
        halt = 1'b0; jump = 1'b1; jaddr = 32'd55; branch = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("halt_ignore", o_pc, 32'd7);
        jump = 1'b0; branch = 1'b0; rst_n = 1'b0; tick();
        check("halt_rst_pc", o_pc, 32'h0);
        check("halt_rst_flag", {31'h0, o_halted}, 32'h0);
        rst_n = 1'b1; tick();
        check("reboot_pc", o_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
